// File: rtl/clause_bin_loader_pkg.sv
// Shared definitions for the clause bin loader and the bin memory controller:
// sequencer state encoding and the {len, clause} memory word packing.
package clause_bin_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_LAST,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_NUM_VARS    = 8;
  localparam int unsigned DEF_WIDTH_C_LEN = 4;

  // Width of one bin memory word: 2 bits per variable plus the length field
  function automatic int unsigned clause_word_w(input int unsigned num_vars,
                                                input int unsigned width_c_len);
    return num_vars * 2 + width_c_len;
  endfunction

  // Memory word layout at the default sizes, length in the upper bits
  typedef struct packed {
    logic [DEF_WIDTH_C_LEN-1:0] len;
    logic [DEF_NUM_VARS*2-1:0]  clause;
  } clause_word_t;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot slot strobe decoder; all zeros when not enabled.
module onehot_dec #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/clause_bin_loader.sv
// Streams a clause bin from bin memory into the clause array (load) and writes
// the array's valid slots back to the same bin location (update).
module clause_bin_loader
  import clause_bin_loader_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_C_LEN = 4,
  parameter int unsigned WIDTH_ADDR  = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start_load_i,
  input  logic                                          start_update_i,
  input  logic [WIDTH_ADDR-1:0]                         base_addr_i,
  input  logic [$clog2(NUM_CLAUSES):0]                  num_clauses_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic [WIDTH_ADDR-1:0]                         mem_addr_o,
  output logic                                          mem_rd_o,
  output logic                                          mem_we_o,
  input  logic [clause_word_w(NUM_VARS, WIDTH_C_LEN)-1:0] mem_data_i,
  output logic [clause_word_w(NUM_VARS, WIDTH_C_LEN)-1:0] mem_data_o,
  output logic [NUM_CLAUSES-1:0]                        wr_o,
  output logic [NUM_CLAUSES-1:0]                        rd_o,
  output logic [NUM_VARS*2-1:0]                         clause_o,
  output logic [WIDTH_C_LEN-1:0]                        clause_len_o,
  input  logic [NUM_VARS*2-1:0]                         clause_i,
  input  logic [WIDTH_C_LEN-1:0]                        clause_len_i
);

  localparam int unsigned CNT_W  = $clog2(NUM_CLAUSES) + 1;
  localparam int unsigned IDX_W  = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int unsigned WORD_W = clause_word_w(NUM_VARS, WIDTH_C_LEN);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CLAUSES - 1);
  localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(NUM_CLAUSES);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        num_q, num_d;
  logic [WIDTH_ADDR-1:0]   base_q, base_d;
  logic                    wr_vld_q, wr_vld_d;
  logic                    wr_mem_q, wr_mem_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;

  logic [CNT_W-1:0]        num_clamp;
  logic [WIDTH_ADDR-1:0]   slot_addr;
  logic                    rd_en;

  assign num_clamp = (num_clauses_i > MAX_N) ? MAX_N : num_clauses_i;
  assign slot_addr = base_q + WIDTH_ADDR'(cnt_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      base_q   <= '0;
      wr_vld_q <= 1'b0;
      wr_mem_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      base_q   <= base_d;
      wr_vld_q <= wr_vld_d;
      wr_mem_q <= wr_mem_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // Next state, counters and same-cycle memory/array strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    base_d     = base_q;
    wr_vld_d   = 1'b0;
    wr_mem_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    busy_o     = (state_q != ST_IDLE);
    done_o     = 1'b0;
    mem_rd_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_load_i) begin
          base_d  = base_addr_i;
          num_d   = num_clamp;
          state_d = ST_LOAD;
        end else if (start_update_i) begin
          base_d  = base_addr_i;
          num_d   = num_clamp;
          state_d = (num_clamp == '0) ? ST_DONE : ST_UPDATE;
        end
      end

      // Read slot k now; its array write follows one cycle later
      ST_LOAD: begin
        if (cnt_q < num_q) begin
          mem_rd_o   = 1'b1;
          mem_addr_o = slot_addr;
        end
        wr_vld_d = 1'b1;
        wr_mem_d = (cnt_q < num_q);
        wr_idx_d = IDX_W'(cnt_q);
        if (cnt_q == LAST_SLOT) state_d = ST_LOAD_LAST;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end

      ST_LOAD_LAST: state_d = ST_DONE;

      ST_UPDATE: begin
        rd_en      = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = slot_addr;
        mem_data_o = WORD_W'({clause_len_i, clause_i});
        if (cnt_q == num_q - CNT_W'(1)) state_d = ST_DONE;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end

      ST_DONE: begin
        done_o  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Slots past the bin's clause count are written as empty clauses
  always_comb begin
    {clause_len_o, clause_o} = '0;
    if (wr_vld_q && wr_mem_q) {clause_len_o, clause_o} = mem_data_i;
  end

  onehot_dec #(
    .WIDTH (NUM_CLAUSES),
    .IDX_W (IDX_W)
  ) u_wr_dec (
    .en_i     (wr_vld_q),
    .idx_i    (wr_idx_q),
    .onehot_o (wr_o)
  );

  onehot_dec #(
    .WIDTH (NUM_CLAUSES),
    .IDX_W (IDX_W)
  ) u_rd_dec (
    .en_i     (rd_en),
    .idx_i    (IDX_W'(cnt_q)),
    .onehot_o (rd_o)
  );

endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader with a bin memory model and a clause
// array model; every output is compared cycle by cycle against hand values.
module tb_clause_bin_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load_i;
  logic        start_update_i;
  logic [9:0]  base_addr_i;
  logic [3:0]  num_clauses_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  mem_addr_o;
  logic        mem_rd_o;
  logic        mem_we_o;
  logic [19:0] mem_data_i;
  logic [19:0] mem_data_o;
  logic [7:0]  wr_o;
  logic [7:0]  rd_o;
  logic [15:0] clause_o;
  logic [3:0]  clause_len_o;
  logic [15:0] clause_i;
  logic [3:0]  clause_len_i;

  logic [19:0] mem [1024];

  int tests = 0;
  int fails = 0;

  clause_bin_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start_load_i   (start_load_i),
    .start_update_i (start_update_i),
    .base_addr_i    (base_addr_i),
    .num_clauses_i  (num_clauses_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rd_o       (mem_rd_o),
    .mem_we_o       (mem_we_o),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .wr_o           (wr_o),
    .rd_o           (rd_o),
    .clause_o       (clause_o),
    .clause_len_o   (clause_len_o),
    .clause_i       (clause_i),
    .clause_len_i   (clause_len_i)
  );

  always #5 clk = ~clk;

  // Bin memory: read data valid one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
  end

  // Clause array: slot k returns clause 16'h5500+k, length 2
  always_comb begin
    clause_i     = '0;
    clause_len_i = '0;
    for (int i = 0; i < 8; i++) begin
      if (rd_o[i]) begin
        clause_i     = 16'h5500 + 16'(i);
        clause_len_i = 4'd2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_wr"}, 32'(wr_o), 32'd0);
    check({tag, "_rd"}, 32'(rd_o), 32'd0);
    check({tag, "_memrd"}, 32'(mem_rd_o), 32'd0);
    check({tag, "_memwe"}, 32'(mem_we_o), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_wdata"}, 32'(mem_data_o), 32'd0);
    check({tag, "_cl"}, 32'({clause_len_o, clause_o}), 32'd0);
  endtask

  // Load of one bin; optional simultaneous update start and mid-load update pulse
  task automatic run_load(input logic [9:0] base, input logic [3:0] n_in, input int n_eff,
                          input bit both, input int upd_cyc);
    int          rd_cnt;
    int          s;
    logic [7:0]  exp_wr;
    logic [19:0] exp_d;
    logic [9:0]  exp_a;
    bit          exp_rd;
    for (int k = 0; k < 8; k++) mem[base + 10'(k)] = {4'(k + 1), 16'hA000 + 16'(k)};
    start_load_i   = 1'b1;
    start_update_i = both;
    base_addr_i    = base;
    num_clauses_i  = n_in;
    @(negedge clk);
    check("ld_c0_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    start_load_i   = 1'b0;
    start_update_i = 1'b0;
    rd_cnt = 0;
    for (int c = 1; c <= 11; c++) begin
      start_update_i = (c == upd_cyc);
      @(negedge clk);
      exp_rd = (c <= 8) && ((c - 1) < n_eff);
      exp_a  = exp_rd ? base + 10'(c - 1) : 10'd0;
      exp_wr = 8'd0;
      exp_d  = 20'd0;
      if (c >= 2 && c <= 9) begin
        s      = c - 2;
        exp_wr = 8'd1 << s;
        if (s < n_eff) exp_d = {4'(s + 1), 16'hA000 + 16'(s)};
      end
      if (mem_rd_o) rd_cnt++;
      check("ld_busy", 32'(busy_o), 32'(c <= 10));
      check("ld_done", 32'(done_o), 32'(c == 10));
      check("ld_memrd", 32'(mem_rd_o), 32'(exp_rd));
      check("ld_addr", 32'(mem_addr_o), 32'(exp_a));
      check("ld_wr", 32'(wr_o), 32'(exp_wr));
      check("ld_data", 32'({clause_len_o, clause_o}), 32'(exp_d));
      check("ld_arr_rd", 32'(rd_o), 32'd0);
      check("ld_memwe", 32'(mem_we_o), 32'd0);
      @(posedge clk); #1;
    end
    start_update_i = 1'b0;
    check("ld_rd_count", 32'(rd_cnt), 32'(n_eff));
  endtask

  // Write-back of n slots starting at base
  task automatic run_update(input logic [9:0] base, input logic [3:0] n);
    bit act;
    int k;
    start_update_i = 1'b1;
    base_addr_i    = base;
    num_clauses_i  = n;
    @(negedge clk);
    check("up_c0_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    start_update_i = 1'b0;
    for (int c = 1; c <= int'(n) + 2; c++) begin
      @(negedge clk);
      k   = c - 1;
      act = (c <= int'(n));
      check("up_we", 32'(mem_we_o), 32'(act));
      check("up_rd", 32'(rd_o), act ? 32'(8'd1 << k) : 32'd0);
      check("up_addr", 32'(mem_addr_o), act ? 32'(base + 10'(k)) : 32'd0);
      check("up_data", 32'(mem_data_o), act ? 32'({4'd2, 16'h5500 + 16'(k)}) : 32'd0);
      check("up_done", 32'(done_o), 32'(c == int'(n) + 1));
      check("up_busy", 32'(busy_o), 32'(c <= int'(n) + 1));
      check("up_wr", 32'(wr_o), 32'd0);
      check("up_memrd", 32'(mem_rd_o), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int wr_cnt;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_data_i     = '0;
    rst            = 1'b0;
    start_load_i   = 1'b0;
    start_update_i = 1'b0;
    base_addr_i    = '0;
    num_clauses_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_load(10'h040, 4'd8, 8, 1'b0, 0);        // full bin
    run_load(10'h100, 4'd3, 3, 1'b0, 0);        // partial bin, stale slots cleared
    run_update(10'h200, 4'd5);
    run_update(10'h200, 4'd0);                  // empty bin: done without writes
    run_load(10'h080, 4'd8, 8, 1'b1, 3);        // load wins, mid-load update ignored
    run_load(10'h3FE, 4'd4, 4, 1'b0, 0);        // address wrap
    run_load(10'h010, 4'd15, 8, 1'b0, 0);       // count clamped to 8

    // Reset asserted during cycle 4 of a load
    start_load_i  = 1'b1;
    base_addr_i   = 10'h050;
    num_clauses_i = 4'd8;
    @(posedge clk); #1;
    start_load_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b1;
    done_cnt = 0;
    wr_cnt   = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (wr_o != 8'd0 || mem_we_o) wr_cnt++;
    end
    check("midrst_done_count", 32'(done_cnt), 32'd0);
    check("midrst_wr_count", 32'(wr_cnt), 32'd0);
    check("midrst_idle_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clause_bin_loader.md
# clause_bin_loader

Sequencer directly upstream of the clause array. On a load command it streams one clause bin from the bin memory into the array's clause slots, one slot per cycle, using the one-hot `wr`/`clause`/`clause_len` load path. On an update command it reads every valid slot back through the one-hot `rd`/`clause` path and writes it to the same bin location, so learnt-clause changes persist before the bin is swapped out.

## Interface
- `NUM_CLAUSES`, default 8: number of clause slots in the array; must be a power of two.
- `NUM_VARS`, default 8: variables per clause; each clause uses 2 bits per variable.
- `WIDTH_C_LEN`, default 4: width of the clause-length field.
- `WIDTH_ADDR`, default 10: bin memory address width.
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset; synchronous, active-low.
- `start_load_i`  in  1  — one-cycle command: load a bin.
- `start_update_i`  in  1  — one-cycle command: write the bin back.
- `base_addr_i`  in  WIDTH_ADDR  — memory address of slot 0 of the bin.
- `num_clauses_i`  in  $clog2(NUM_CLAUSES)+1  — number of valid clauses in the bin.
- `busy_o`  out  1  — a command is in progress.
- `done_o`  out  1  — one-cycle pulse when a command completes.
- `mem_addr_o`  out  WIDTH_ADDR  — bin memory address.
- `mem_rd_o`  out  1  — memory read strobe.
- `mem_we_o`  out  1  — memory write strobe.
- `mem_data_i`  in  NUM_VARS*2+WIDTH_C_LEN  — read word `{len, clause}`; valid 1 cycle after `mem_rd_o`.
- `mem_data_o`  out  NUM_VARS*2+WIDTH_C_LEN  — write word `{len, clause}`.
- `wr_o`  out  NUM_CLAUSES  — one-hot slot write to the clause array.
- `rd_o`  out  NUM_CLAUSES  — one-hot slot read from the clause array.
- `clause_o`  out  NUM_VARS*2  — clause bits sent to the array.
- `clause_len_o`  out  WIDTH_C_LEN  — clause length sent to the array.
- `clause_i`  in  NUM_VARS*2  — clause bits from the array; combinational on `rd_o`, same cycle.
- `clause_len_i`  in  WIDTH_C_LEN  — length of the slot selected by `rd_o`, same cycle.

## Operation
- **FSM states:** IDLE, LOAD, LOAD_LAST, UPDATE, DONE.
- **Command capture (IDLE only):**
  - A start command latches `base_addr_i` and `num_clauses_i`.
  - `num_clauses_i` values above NUM_CLAUSES are clamped to NUM_CLAUSES.
  - Starts arriving while busy are ignored.
  - If `start_load_i` and `start_update_i` are high together, load wins.
- **LOAD:**
  - A slot counter k runs from 0 to NUM_CLAUSES-1, one step per cycle.
  - Memory access: if k < N, assert `mem_rd_o` with `mem_addr_o` = base+k.
  - Array write, one cycle later (pipelined), for slot k:
    - k < N: `wr_o` = one-hot(k), `{clause_len_o, clause_o}` = `mem_data_i`.
    - k >= N: `wr_o` = one-hot(k), with clause = 0 and len = 0. This clears stale slots.
  - After the last issue cycle, go to LOAD_LAST to perform the final write, then DONE.
- **UPDATE:**
  - For k = 0 to N-1: `rd_o` = one-hot(k), `mem_we_o` = 1, `mem_addr_o` = base+k, `mem_data_o` = `{clause_len_i, clause_i}`. All of these are combinational in the same cycle.
  - After slot N-1, go to DONE.
  - If N = 0, go straight to DONE with no writes.
- **DONE:** pulse `done_o` for one cycle, then return to IDLE.
- **Address arithmetic:** base+k is computed modulo 2^WIDTH_ADDR; it wraps silently.
- **Idle outputs:** `wr_o`, `rd_o`, `mem_rd_o` and `mem_we_o` are 0 whenever not active in the current cycle.

## Timing
- **Reset:** all outputs are 0, the FSM is in IDLE and the counter is 0.
- **Mid-operation reset:** `rst` low mid-command aborts to IDLE on the next edge. No `done_o` is produced, and no further `wr_o` or `mem_we_o` is issued.
- **Load latency:** start accepted at cycle 0. LOAD begins at cycle 1. `wr_o` for slot 0 appears at cycle 2 and for slot NUM_CLAUSES-1 at cycle NUM_CLAUSES+1. `done_o` fires at cycle NUM_CLAUSES+2.
- **Update latency:** start at cycle 0; writes occur at cycles 1..N; `done_o` fires at cycle N+1.
- **Busy window:** `busy_o` is high from the cycle after the accepted start through the `done_o` cycle inclusive.
- **Strobe exclusivity:** at most one bit of `wr_o` or `rd_o` is set in any cycle, and `wr_o` and `rd_o` are never both nonzero.

## Structure
- **Shared package:** FSM state encoding, and the clause-word packing `{len, clause}` and its width (NUM_VARS*2+WIDTH_C_LEN), shared with the bin memory controller.
- **Sub-module:** one sub-module, `onehot_dec` (index → one-hot of width NUM_CLAUSES). It is reused for `wr_o` and `rd_o`.

## Test plan
- **Full load:** N=8, base=0x040, memory word k = `{len=k+1, clause=16'hA000+k}` → `wr_o` 8'h01..8'h80 on cycles 2..9 with matching data; `done_o` at cycle 10.
- **Partial load:** N=3 → slots 0-2 receive memory data; slots 3-7 are written with clause 0, len 0; `mem_rd_o` is high for exactly 3 cycles.
- **Update:** N=5, array slot k returns clause 16'h5500+k, len 2 → `mem_we_o` at addresses base..base+4 with `{2, 16'h5500+k}`; `done_o` at cycle 6; N=0 → `done_o` at cycle 1 with no writes.
- **Arbitration and busy:** start_load and start_update in the same cycle → load runs; `start_update_i` pulsed mid-load → ignored, with no `rd_o` activity.
- **Reset mid-load:** `rst`=0 at cycle 4 of a load → the next cycle has all outputs 0 and `busy_o`=0, and `done_o` never pulses.
- **Wrap and clamp:** base=0x3FE with N=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; `num_clauses_i`=15 → treated as 8.
